// File: rtl/switch_input_comparator.sv
// switch_input_comparator
// Elevator call classifier for a 4-floor car. A newly pressed floor call is
// marked for insertion at the head of the floor memory when it lies strictly
// between the car's current floor and its current trip target, in the
// direction of travel. Otherwise it is marked for appending at the tail.
// All outputs are registered, so results appear one cycle after the call.
//
// Optional feature: define SWITCH_CMP_DUP_FILTER_EN to drop calls that repeat
// the current trip target. Such a call raises dup_call instead of out_valid.
// The default build leaves the macro undefined, and dup_call is then tied 0.

module switch_input_comparator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       down_up_Flag,
  input  logic [1:0] pos0Mem,
  input  logic       down_up_Input,
  input  logic [1:0] floorCall_Input,
  input  logic [1:0] actualFloor,
  input  logic       call_valid,
  output logic [1:0] nextMemoryFloor,
  output logic       BeginEndMemory_Flag,
  output logic       out_valid,
  output logic       dup_call
);

  // Direction encoding shared by the car state and the call request.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  dir_e car_dir;
  dir_e call_dir;

  logic       up_between;
  logic       down_between;
  logic       head;
  logic       is_dup;

  logic [1:0] next_floor_d, next_floor_q;
  logic       begin_end_d,  begin_end_q;
  logic       out_valid_d,  out_valid_q;
  logic       dup_call_d,   dup_call_q;

  assign car_dir  = dir_e'(down_up_Flag);
  assign call_dir = dir_e'(down_up_Input);

  // Head-insert decision: the call must match the travel direction and lie
  // strictly between the current floor and the trip target. All compares are
  // unsigned 2-bit, so a call equal to either end point goes to the tail.
  always_comb begin
    up_between   = (actualFloor < floorCall_Input) && (floorCall_Input < pos0Mem);
    down_between = (pos0Mem < floorCall_Input) && (floorCall_Input < actualFloor);
    head         = ((car_dir == DIR_UP)   && (call_dir == DIR_UP)   && up_between)
                 | ((car_dir == DIR_DOWN) && (call_dir == DIR_DOWN) && down_between);
`ifdef SWITCH_CMP_DUP_FILTER_EN
    is_dup       = (floorCall_Input == pos0Mem);
`else
    is_dup       = 1'b0;
`endif
  end

  // Next-state logic: a valid call loads the data registers and pulses
  // out_valid. A filtered duplicate pulses dup_call and leaves the data alone.
  // With no call, both pulses drop and the data holds.
  always_comb begin
    // NOTE: every signal gets a default first. That keeps this combinational
    // block from inferring latches on paths that do not assign it.
    next_floor_d = next_floor_q;
    begin_end_d  = begin_end_q;
    out_valid_d  = 1'b0;
    dup_call_d   = 1'b0;
    if (call_valid) begin
      if (is_dup) begin
        dup_call_d = 1'b1;
      end else begin
        next_floor_d = floorCall_Input;
        begin_end_d  = head;
        out_valid_d  = 1'b1;
      end
    end
  end

  // Output registers. The synchronous active-low reset takes priority over a
  // call that arrives in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      next_floor_q <= 2'd0;
      begin_end_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      dup_call_q   <= 1'b0;
    end else begin
      next_floor_q <= next_floor_d;
      begin_end_q  <= begin_end_d;
      out_valid_q  <= out_valid_d;
      dup_call_q   <= dup_call_d;
    end
  end

  assign nextMemoryFloor     = next_floor_q;
  assign BeginEndMemory_Flag = begin_end_q;
  assign out_valid           = out_valid_q;
  assign dup_call            = dup_call_q;

endmodule

// File: tb/tb_switch_input_comparator.sv
// Directed testbench for switch_input_comparator. Each step drives one set of
// inputs and crosses one rising edge. The step then compares all four outputs
// against hand-computed values.
// Expected values follow SWITCH_CMP_DUP_FILTER_EN when it is defined.

module tb_switch_input_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       down_up_Flag;
  logic [1:0] pos0Mem;
  logic       down_up_Input;
  logic [1:0] floorCall_Input;
  logic [1:0] actualFloor;
  logic       call_valid;
  logic [1:0] nextMemoryFloor;
  logic       BeginEndMemory_Flag;
  logic       out_valid;
  logic       dup_call;

  int vectors     = 0;
  int miscompares = 0;

  switch_input_comparator dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .down_up_Flag        (down_up_Flag),
    .pos0Mem             (pos0Mem),
    .down_up_Input       (down_up_Input),
    .floorCall_Input     (floorCall_Input),
    .actualFloor         (actualFloor),
    .call_valid          (call_valid),
    .nextMemoryFloor     (nextMemoryFloor),
    .BeginEndMemory_Flag (BeginEndMemory_Flag),
    .out_valid           (out_valid),
    .dup_call            (dup_call)
  );

  always #5 clk = ~clk;

  // Drive one vector, cross one rising edge, and settle 1 time unit after it.
  task automatic step(input logic rst, input logic flag, input logic [1:0] act,
                      input logic [1:0] pos0, input logic dir,
                      input logic [1:0] call, input logic vld);
    rst_n           = rst;
    down_up_Flag    = flag;
    actualFloor     = act;
    pos0Mem         = pos0;
    down_up_Input   = dir;
    floorCall_Input = call;
    call_valid      = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] nmf, input logic bem,
                       input logic ov, input logic dup);
    vectors++;
    assert ({nextMemoryFloor, BeginEndMemory_Flag, out_valid, dup_call} === {nmf, bem, ov, dup})
    else begin
      miscompares++;
      $error("FAIL %s: observed nmf=%0d bem=%0b ov=%0b dup=%0b, expected nmf=%0d bem=%0b ov=%0b dup=%0b",
             tag, nextMemoryFloor, BeginEndMemory_Flag, out_valid, dup_call, nmf, bem, ov, dup);
    end
  endtask

  initial begin
    // Step argument order: rst, flag, actual, pos0, dir, call, valid.
    step(0, 0, 0, 0, 0, 0, 0);  check("reset_idle",          2'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3, 1);  check("reset_hold",          2'd0, 0, 0, 0);
    step(1, 1, 0, 2, 1, 1, 1);  check("up_between_head",     2'd1, 1, 1, 0);
    step(1, 1, 0, 2, 0, 1, 1);  check("up_dir_mismatch",     2'd1, 0, 1, 0);
    step(1, 0, 3, 1, 0, 2, 1);  check("down_between_head",   2'd2, 1, 1, 0);
    step(1, 0, 1, 0, 0, 2, 1);  check("down_above_actual",   2'd2, 0, 1, 0);
    step(1, 0, 3, 2, 0, 1, 1);  check("down_beyond_target",  2'd1, 0, 1, 0);
    step(1, 1, 1, 3, 0, 2, 1);  check("up_call_down",        2'd2, 0, 1, 0);
    step(1, 1, 1, 3, 1, 1, 1);  check("up_equal_actual",     2'd1, 0, 1, 0);
    step(1, 1, 0, 3, 1, 2, 1);  check("up_head_0_to_3",      2'd2, 1, 1, 0);
    step(1, 1, 0, 3, 1, 1, 0);  check("idle_hold",           2'd2, 1, 0, 0);
    step(1, 1, 0, 3, 1, 0, 0);  check("idle_hold_2",         2'd2, 1, 0, 0);
    step(0, 1, 0, 3, 1, 2, 1);  check("reset_mid_stream",    2'd0, 0, 0, 0);
    step(1, 1, 0, 3, 1, 1, 1);  check("after_reset_head",    2'd1, 1, 1, 0);
`ifdef SWITCH_CMP_DUP_FILTER_EN
    step(1, 1, 0, 2, 1, 2, 1);  check("dup_filtered",        2'd1, 1, 0, 1);
`else
    step(1, 1, 0, 2, 1, 2, 1);  check("dup_as_tail",         2'd2, 0, 1, 0);
`endif
    step(1, 1, 0, 2, 1, 2, 0);
`ifdef SWITCH_CMP_DUP_FILTER_EN
    check("dup_pulse_end", 2'd1, 1, 0, 0);
`else
    check("dup_pulse_end", 2'd2, 0, 0, 0);
`endif
    step(1, 0, 2, 0, 0, 1, 1);  check("down_head_2_to_0",    2'd1, 1, 1, 0);
    step(1, 0, 2, 0, 0, 2, 1);  check("down_equal_actual",   2'd2, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
